// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte widths, the byte type, the FIPS-197
// inverse S-box table and a helper that locates a state byte in the 128-bit word.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = AES_STATE_W / AES_BYTE_W;

    typedef logic [AES_BYTE_W-1:0] aes_byte_t;

    // Inverse S-box, indexed by the substituted byte value.
    localparam aes_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Byte 0 is the most significant byte; returns the MSB position of byte idx.
    function automatic int byte_msb(input int idx);
        return AES_STATE_W - 1 - AES_BYTE_W * idx;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Single combinational inverse S-box: one byte in, its substitution out.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] data,
    output logic [AES_BYTE_W-1:0] result
);

    assign result = INV_SBOX[data];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: a captured state is substituted in place, LANES bytes
// per cycle through LANES shared inverse S-boxes, then held until taken.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
);

    localparam int         NCYC     = AES_NBYTES / LANES;
    localparam logic [3:0] LAST_CNT = 4'(NCYC - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]             fsm;
    logic [AES_STATE_W-1:0] st;
    logic [AES_STATE_W-1:0] st_next;
    logic [3:0]             cnt;
    logic [NCYC-1:0]        grp_sel;
    aes_byte_t              lane_src [LANES];
    aes_byte_t              lane_sub [LANES];

    // One-hot decode of which byte group is being substituted this cycle.
    for (genvar g = 0; g < NCYC; g++) begin : g_sel
        assign grp_sel[g] = (cnt == 4'(g));
    end

    // Each lane sees byte g*LANES+l of group g; cnt picks the group by shifting.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [NCYC*AES_BYTE_W-1:0] lane_bus;

        for (genvar g = 0; g < NCYC; g++) begin : g_grp
            assign lane_bus[g*AES_BYTE_W +: AES_BYTE_W] =
                st[byte_msb(g*LANES + l) -: AES_BYTE_W];
        end

        assign lane_src[l] = aes_byte_t'(lane_bus >> {cnt, 3'b000});

        inv_sbox u_inv_sbox (
            .data   (lane_src[l]),
            .result (lane_sub[l])
        );
    end

    // Next state value: the active group takes its substituted bytes, the rest hold.
    for (genvar g = 0; g < NCYC; g++) begin : g_wb_grp
        for (genvar l = 0; l < LANES; l++) begin : g_wb_lane
            assign st_next[byte_msb(g*LANES + l) -: AES_BYTE_W] =
                grp_sel[g] ? lane_sub[l] : st[byte_msb(g*LANES + l) -: AES_BYTE_W];
        end
    end

    // Control FSM: capture in IDLE, substitute one group per cycle in RUN, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
            st  <= '0;
            cnt <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        st  <= in_data;
                        cnt <= '0;
                        fsm <= RUN;
                    end
                end
                RUN: begin
                    st <= st_next;
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        fsm <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm <= IDLE;
                    end
                end
                default: begin
                    fsm <= IDLE;
                    cnt <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm == RUN) || (fsm == DONE);
    assign out_data  = st;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Self-checking bench for inv_sub_bytes_iter with LANES = 4, 1 and 16.
// Expected states come from known vectors or from an independent GF(2^8) model,
// are queued when a state is accepted and popped when the DUT presents a result.
module tb_inv_sub_bytes_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];

    int           cyc    = 0;
    int           errors = 0;
    int           checks = 0;
    logic [127:0] sb_q [$];

    localparam logic [127:0] C1_IN   = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
    localparam logic [127:0] C1_OUT  = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] CNT_IN  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CNT_OUT = 128'h52096ad53036a538bf40a39e81f3d7fb;

    inv_sub_bytes_iter #(.LANES(4)) dut_l4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0])
    );

    inv_sub_bytes_iter #(.LANES(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1])
    );

    inv_sub_bytes_iter #(.LANES(16)) dut_l16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .busy(busy[2])
    );

    // Free-running clock and an edge counter used for latency measurements.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something unexpected stalls the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            if (aa[7]) aa = {aa[6:0], 1'b0} ^ 8'h1b;
            else       aa = {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Inverse affine transform followed by the multiplicative inverse.
    function automatic logic [7:0] model_inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        if (y == 8'h00) return 8'h00;
        for (int i = 1; i < 256; i++) begin
            if (gf_mul(y, 8'(i)) == 8'h01) return 8'(i);
        end
        return 8'h00;
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] s);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) begin
            r = {r[119:0], model_inv_sbox(8'(s >> (8 * (15 - i))))};
        end
        return r;
    endfunction

    function automatic int ncyc_of(input logic [1:0] k);
        case (k)
            2'd0:    return 4;
            2'd1:    return 16;
            default: return 1;
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        in_valid[0] = 1'b0; in_data[0] = '0; out_ready[0] = 1'b0;
        in_valid[1] = 1'b0; in_data[1] = '0; out_ready[1] = 1'b0;
        in_valid[2] = 1'b0; in_data[2] = '0; out_ready[2] = 1'b0;
    endtask

    // Offer one state; the expected result is queued on the accepting edge.
    task automatic send(input logic [1:0] k, input logic [127:0] data,
                        input logic [127:0] exp, output bit ok);
        ok = 1'b0;
        in_data[k]  = data;
        in_valid[k] = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (in_ready[k] === 1'b1) begin
                step();
                sb_q.push_back(exp);
                ok = 1'b1;
                break;
            end
            step();
        end
        in_valid[k] = 1'b0;
    endtask

    // Count edges from the accept until out_valid appears (bounded).
    task automatic wait_done(input logic [1:0] k, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (out_valid[k] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
            lat++;
        end
    endtask

    task automatic pop_expected(output logic [127:0] exp, output bit ok);
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            ok  = 1'b1;
        end else begin
            exp = '0;
            ok  = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [1:0] k;
        rst_n = 1'b0;
        idle_all();
        step();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3; i++) begin
                k = 2'(i);
                checks++;
                if (in_ready[k] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL reset_in_ready[%0d] pass %0d: got %b, want 1", i, pass, in_ready[k]);
                end
                checks++;
                if (out_valid[k] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_out_valid[%0d] pass %0d: got %b, want 0", i, pass, out_valid[k]);
                end
                checks++;
                if (out_data[k] !== 128'h0) begin
                    errors++;
                    $display("[TB] FAIL reset_out_data[%0d] pass %0d: got %h, want 0", i, pass, out_data[k]);
                end
                checks++;
                if (busy[k] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_busy[%0d] pass %0d: got %b, want 0", i, pass, busy[k]);
                end
            end
            if (pass == 0) begin
                @(negedge clk);
                rst_n = 1'b1;
                step();
            end
        end
    endtask

    task automatic test_vectors();
        logic [127:0] vin, vexp, exp;
        int           lat;
        bit           ok;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0:       begin vin = CNT_IN;          vexp = CNT_OUT;          end
                1:       begin vin = {16{8'h63}};     vexp = 128'h0;           end
                2:       begin vin = {16{8'hff}};     vexp = {16{8'h7d}};      end
                3:       begin vin = {16{8'h7c}};     vexp = {16{8'h01}};      end
                4:       begin vin = C1_IN;           vexp = C1_OUT;           end
                default: begin
                    vin  = {$urandom, $urandom, $urandom, $urandom};
                    vexp = model_state(vin);
                end
            endcase
            send(2'd0, vin, vexp, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL vec%0d_accept: got no accept, want accept", i);
            end
            wait_done(2'd0, lat, ok);
            checks++;
            if (!ok || lat != 4) begin
                errors++;
                $display("[TB] FAIL vec%0d_latency: got %0d, want 4", i, lat);
            end
            checks++;
            if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL vec%0d_done_flags: got busy=%b in_ready=%b, want busy=1 in_ready=0",
                         i, busy[0], in_ready[0]);
            end
            pop_expected(exp, ok);
            checks++;
            if (!ok || out_data[0] !== exp) begin
                errors++;
                $display("[TB] FAIL vec%0d_data: got %h, want %h", i, out_data[0], exp);
            end
            out_ready[0] = 1'b1;
            step();
            out_ready[0] = 1'b0;
            checks++;
            if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL vec%0d_release: got out_valid=%b in_ready=%b, want 0/1",
                         i, out_valid[0], in_ready[0]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] exp;
        int           lat;
        bit           ok;
        send(2'd0, C1_IN, C1_OUT, ok);
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrun_reset_flags: got in_ready=%b out_valid=%b busy=%b, want 1/0/0",
                     in_ready[0], out_valid[0], busy[0]);
        end
        checks++;
        if (out_data[0] !== 128'h0) begin
            errors++;
            $display("[TB] FAIL midrun_reset_data: got %h, want 0", out_data[0]);
        end
        if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send(2'd0, CNT_IN, CNT_OUT, ok);
        wait_done(2'd0, lat, ok);
        checks++;
        if (!ok || lat != 4) begin
            errors++;
            $display("[TB] FAIL midrun_after_latency: got %0d, want 4", lat);
        end
        pop_expected(exp, ok);
        checks++;
        if (!ok || out_data[0] !== exp) begin
            errors++;
            $display("[TB] FAIL midrun_after_data: got %h, want %h", out_data[0], exp);
        end
        out_ready[0] = 1'b1;
        step();
        out_ready[0] = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [127:0] exp;
        int           lat;
        bit           ok;
        send(2'd0, C1_IN, C1_OUT, ok);
        wait_done(2'd0, lat, ok);
        pop_expected(exp, ok);
        checks++;
        if (!ok || out_valid[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_reach_done: got out_valid=%b, want 1", out_valid[0]);
        end
        // A new offer while DONE must be ignored.
        in_data[0]  = CNT_IN;
        in_valid[0] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            checks++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold_flags cycle %0d: got out_valid=%b in_ready=%b, want 1/0",
                         n, out_valid[0], in_ready[0]);
            end
            checks++;
            if (out_data[0] !== exp) begin
                errors++;
                $display("[TB] FAIL bp_hold_data cycle %0d: got %h, want %h", n, out_data[0], exp);
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        step();
        out_ready[0] = 1'b0;
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release: got out_valid=%b in_ready=%b, want 0/1",
                     out_valid[0], in_ready[0]);
        end
        step();
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_no_stray_accept: got busy=%b, want 0", busy[0]);
        end
    endtask

    task automatic test_back_to_back(input logic [1:0] k);
        logic [127:0] d1, e1, exp;
        int           acc_q [$];
        int           out_q [$];
        int           nacc = 0;
        int           nc   = ncyc_of(k);
        bit           pre, ok;
        d1 = {$urandom, $urandom, $urandom, $urandom};
        e1 = model_state(d1);
        out_ready[k] = 1'b1;
        in_data[k]   = C1_IN;
        in_valid[k]  = 1'b1;
        for (int n = 0; n < 80 && out_q.size() < 2; n++) begin
            pre = (in_valid[k] === 1'b1) && (in_ready[k] === 1'b1);
            step();
            if (pre) begin
                acc_q.push_back(cyc);
                sb_q.push_back(nacc == 0 ? C1_OUT : e1);
                nacc++;
                if (nacc == 1) in_data[k] = d1;
                else           in_valid[k] = 1'b0;
            end
            if (out_valid[k] === 1'b1) begin
                pop_expected(exp, ok);
                checks++;
                if (!ok || out_data[k] !== exp) begin
                    errors++;
                    $display("[TB] FAIL b2b[%0d]_data%0d: got %h, want %h", k, out_q.size(), out_data[k], exp);
                end
                out_q.push_back(cyc);
            end
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        checks++;
        if (out_q.size() != 2 || acc_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL b2b[%0d]_count: got %0d results, want 2", k, out_q.size());
        end else begin
            checks++;
            if (acc_q[1] - acc_q[0] != nc + 2) begin
                errors++;
                $display("[TB] FAIL b2b[%0d]_spacing: got %0d, want %0d", k, acc_q[1] - acc_q[0], nc + 2);
            end
            checks++;
            if (out_q[0] - acc_q[0] != nc) begin
                errors++;
                $display("[TB] FAIL b2b[%0d]_latency0: got %0d, want %0d", k, out_q[0] - acc_q[0], nc);
            end
            checks++;
            if (out_q[1] - acc_q[1] != nc) begin
                errors++;
                $display("[TB] FAIL b2b[%0d]_latency1: got %0d, want %0d", k, out_q[1] - acc_q[1], nc);
            end
        end
        step();
        sb_q.delete();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_reset_mid_run();
        test_backpressure();
        test_back_to_back(2'd0);
        test_back_to_back(2'd1);
        test_back_to_back(2'd2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
